// File: rtl/cn_c2v_gen.sv
// Serial check-node C2V generator: ping-pong buffers of per-edge {sign, col}, then one C2V beat per edge.
// Define CN_C2V_OFFSET_EN for offset-min-sum magnitudes; otherwise plain min-sum.
module cn_c2v_gen #(
    parameter int MSG_WIDTH   = 6,
    parameter int COL_CNT_WID = 7,
    parameter int DEG_MAX     = 32,
    parameter int OFFSET      = 1
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_vld,
    input  logic                           i_sign,
    input  logic [COL_CNT_WID-1:0]         i_col_cnt,
    output logic                           o_in_rdy,
    input  logic                           i_cmp_vld,
    input  logic [2*(MSG_WIDTH-1)-1:0]     i_v2c_abs,
    input  logic [COL_CNT_WID-1:0]         i_v2c_idx,
    input  logic                           i_v2c_sign_tot,
    output logic                           o_c2v_vld,
    input  logic                           i_c2v_rdy,
    output logic [MSG_WIDTH-1:0]           o_c2v,
    output logic [COL_CNT_WID-1:0]         o_c2v_idx,
    output logic                           o_row_done,
    output logic                           o_err_ovf
);
    localparam int ABS_WID = MSG_WIDTH - 1;
    localparam int CNT_WID = $clog2(DEG_MAX + 1);
    localparam int PTR_WID = (DEG_MAX > 1) ? $clog2(DEG_MAX) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_EMIT, ST_DONE} state_t;

    state_t                 state, state_nxt;
    logic                   sign_mem [2][DEG_MAX];
    logic [COL_CNT_WID-1:0] col_mem  [2][DEG_MAX];
    logic [CNT_WID-1:0]     cnt      [2];
    logic [ABS_WID-1:0]     min1_q   [2];
    logic [ABS_WID-1:0]     min2_q   [2];
    logic [COL_CNT_WID-1:0] idx_q    [2];
    logic [1:0]             sign_tot_q;
    logic [1:0]             full_q;
    logic                   wb, rb;
    logic                   err_ovf_q;
    logic [CNT_WID-1:0]     rcnt;

    logic                   wr_acc, wr_room, close_row, rd_last, rd_start;
    logic [PTR_WID-1:0]     rd_sel;
    logic                   ent_sign;
    logic [COL_CNT_WID-1:0] ent_col;
    logic [ABS_WID-1:0]     mag_raw, mag_adj;
    logic                   sgn;

    assign o_in_rdy  = !full_q[wb];
    assign wr_acc    = i_vld && o_in_rdy;
    assign wr_room   = cnt[wb] != CNT_WID'(DEG_MAX);
    assign close_row = i_cmp_vld && !full_q[wb];
    assign o_err_ovf = err_ovf_q;

    // Write side and bank bookkeeping; a bank is never written while full, so writer and reader never share one
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int e = 0; e < DEG_MAX; e++) begin
                    sign_mem[b][e] <= 1'b0;
                    col_mem[b][e]  <= '0;
                end
                cnt[b]    <= '0;
                min1_q[b] <= '0;
                min2_q[b] <= '0;
                idx_q[b]  <= '0;
            end
            sign_tot_q <= '0;
            full_q     <= '0;
            wb         <= 1'b0;
            rb         <= 1'b0;
            err_ovf_q  <= 1'b0;
        end else begin
            if (wr_acc && wr_room) begin
                sign_mem[wb][cnt[wb][PTR_WID-1:0]] <= i_sign;
                col_mem[wb][cnt[wb][PTR_WID-1:0]]  <= i_col_cnt;
                cnt[wb] <= cnt[wb] + CNT_WID'(1);
            end
            if (wr_acc && !wr_room)
                err_ovf_q <= 1'b1;
            if (close_row) begin
                min1_q[wb]     <= i_v2c_abs[ABS_WID-1:0];
                min2_q[wb]     <= i_v2c_abs[2*ABS_WID-1:ABS_WID];
                idx_q[wb]      <= i_v2c_idx;
                sign_tot_q[wb] <= i_v2c_sign_tot;
                full_q[wb]     <= 1'b1;
                wb             <= ~wb;
            end
            if (state == ST_DONE) begin
                full_q[rb] <= 1'b0;
                cnt[rb]    <= '0;
                rb         <= ~rb;
            end
        end
    end

    assign rd_start = (state == ST_IDLE) && full_q[rb] && (cnt[rb] != '0);
    assign rd_last  = (rcnt + CNT_WID'(1)) == cnt[rb];

    always_ff @(posedge i_clk) begin
        if (i_rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (full_q[rb]) state_nxt = (cnt[rb] == '0) ? ST_DONE : ST_EMIT;
            ST_EMIT: if (o_c2v_vld && i_c2v_rdy && rd_last) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        o_row_done = (state == ST_DONE);
    end

    // Entry staged into the output registers: entry 0 on start, otherwise the one after rcnt
    always_comb begin
        rd_sel   = (state == ST_IDLE) ? '0 : PTR_WID'(rcnt + CNT_WID'(1));
        ent_sign = sign_mem[rb][rd_sel];
        ent_col  = col_mem[rb][rd_sel];
        mag_raw  = (ent_col == idx_q[rb]) ? min2_q[rb] : min1_q[rb];
`ifdef CN_C2V_OFFSET_EN
        mag_adj  = (mag_raw > ABS_WID'(OFFSET)) ? mag_raw - ABS_WID'(OFFSET) : '0;
`else
        mag_adj  = mag_raw;
`endif
        sgn      = (mag_adj == '0) ? 1'b0 : (sign_tot_q[rb] ^ ent_sign);
    end

`ifndef CN_C2V_OFFSET_EN
    logic unused_offset;
    assign unused_offset = (OFFSET != 0);
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_c2v_vld <= 1'b0;
            o_c2v     <= '0;
            o_c2v_idx <= '0;
            rcnt      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rd_start) begin
                        o_c2v_vld <= 1'b1;
                        o_c2v     <= {sgn, mag_adj};
                        o_c2v_idx <= ent_col;
                        rcnt      <= '0;
                    end
                end
                ST_EMIT: begin
                    if (o_c2v_vld && i_c2v_rdy) begin
                        if (rd_last) begin
                            o_c2v_vld <= 1'b0;
                        end else begin
                            o_c2v     <= {sgn, mag_adj};
                            o_c2v_idx <= ent_col;
                            rcnt      <= rcnt + CNT_WID'(1);
                        end
                    end
                end
                default: o_c2v_vld <= 1'b0;
            endcase
        end
    end
endmodule

// File: tb/tb_cn_c2v_gen.sv
// Directed bench for cn_c2v_gen (DEG_MAX=4); expectations follow CN_C2V_OFFSET_EN when defined.
module tb_cn_c2v_gen;
    localparam int MW = 6;
    localparam int CW = 7;
    localparam int DM = 4;
`ifdef CN_C2V_OFFSET_EN
    localparam bit OFS = 1'b1;
`else
    localparam bit OFS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          i_rst = 1'b1, i_vld = 1'b0, i_sign = 1'b0, i_cmp_vld = 1'b0;
    logic [CW-1:0] i_col_cnt = '0, i_v2c_idx = '0;
    logic [2*(MW-1)-1:0] i_v2c_abs = '0;
    logic          i_v2c_sign_tot = 1'b0, i_c2v_rdy = 1'b1;
    logic          o_in_rdy, o_c2v_vld, o_row_done, o_err_ovf;
    logic [MW-1:0] o_c2v;
    logic [CW-1:0] o_c2v_idx;

    always #5 clk = ~clk;

    cn_c2v_gen #(.MSG_WIDTH(MW), .COL_CNT_WID(CW), .DEG_MAX(DM), .OFFSET(1)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_vld(i_vld), .i_sign(i_sign), .i_col_cnt(i_col_cnt),
        .o_in_rdy(o_in_rdy), .i_cmp_vld(i_cmp_vld), .i_v2c_abs(i_v2c_abs), .i_v2c_idx(i_v2c_idx),
        .i_v2c_sign_tot(i_v2c_sign_tot), .o_c2v_vld(o_c2v_vld), .i_c2v_rdy(i_c2v_rdy),
        .o_c2v(o_c2v), .o_c2v_idx(o_c2v_idx), .o_row_done(o_row_done), .o_err_ovf(o_err_ovf)
    );

    typedef struct {
        logic          sign;
        logic [CW-1:0] col;
        logic [MW-1:0] exp;
    } edge_t;
    typedef struct {
        logic [4:0]    min1;
        logic [4:0]    min2;
        logic [CW-1:0] idx;
        logic          st;
        int            first;
        int            n_edge;
        int            n_beat;
    } row_t;

    edge_t vt [16];
    row_t  rt [6];
    logic [MW-1:0] bc2v [16];
    logic [CW-1:0] bidx [16];
    int total = 0, bad = 0;
    int nb, ndone, done_gap, first_cyc, nstall;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic close_row(input int r);
        i_cmp_vld      = 1'b1;
        i_v2c_abs      = {rt[r].min2, rt[r].min1};
        i_v2c_idx      = rt[r].idx;
        i_v2c_sign_tot = rt[r].st;
        tick();
        i_cmp_vld = 1'b0;
    endtask

    task automatic load_row(input int r);
        for (int k = 0; k < rt[r].n_edge; k++) begin
            i_vld     = 1'b1;
            i_sign    = vt[rt[r].first + k].sign;
            i_col_cnt = vt[rt[r].first + k].col;
            tick();
        end
        i_vld = 1'b0;
        close_row(r);
    endtask

    // Collect beats of row r, optionally stalling stall_len cycles once stall_after beats were taken
    task automatic drain(input int r, input int stall_after, input int stall_len);
        int stall = 0, last_acc = -100, done_cyc = -100;
        nb = 0; ndone = 0; done_gap = -1; first_cyc = -1;
        for (int cyc = 0; cyc < 60; cyc++) begin
            i_c2v_rdy = !(nb == stall_after && stall < stall_len);
            @(negedge clk);
            if (o_c2v_vld && i_c2v_rdy) begin
                if (nb < 16) begin
                    bc2v[nb] = o_c2v;
                    bidx[nb] = o_c2v_idx;
                end
                if (first_cyc < 0) first_cyc = cyc;
                last_acc = cyc;
                nb++;
            end else if (o_c2v_vld) begin
                stall++;
                if (nb < rt[r].n_beat) begin
                    chk("hold_c2v", o_c2v, vt[rt[r].first + nb].exp);
                    chk("hold_idx", o_c2v_idx, vt[rt[r].first + nb].col);
                end
            end
            if (o_row_done) begin
                ndone++;
                if (done_gap < 0) done_gap = cyc - last_acc;
                done_cyc = cyc;
            end
            tick();
            if (ndone > 0 && cyc >= done_cyc + 2) break;
        end
        i_c2v_rdy = 1'b1;
        nstall = stall;
    endtask

    task automatic check_beats(input string name, input int r, input int base);
        for (int k = 0; k < rt[r].n_beat; k++) begin
            if (base + k < nb && base + k < 16) begin
                chk($sformatf("%s_c2v%0d", name, k), bc2v[base + k], vt[rt[r].first + k].exp);
                chk($sformatf("%s_idx%0d", name, k), bidx[base + k], vt[rt[r].first + k].col);
            end
        end
    endtask

    initial begin
        int c_acc, d0, bfirst, cnt2;
        vt[0]  = '{1'b0, 7'd3,  OFS ? 6'h21 : 6'h22};
        vt[1]  = '{1'b1, 7'd7,  OFS ? 6'h04 : 6'h05};
        vt[2]  = '{1'b0, 7'd9,  OFS ? 6'h21 : 6'h22};
        vt[3]  = '{1'b0, 7'd12, OFS ? 6'h21 : 6'h22};
        vt[4]  = '{1'b1, 7'd1,  OFS ? 6'h22 : 6'h23};
        vt[5]  = '{1'b0, 7'd2,  OFS ? 6'h05 : 6'h06};
        vt[6]  = '{1'b0, 7'd4,  OFS ? 6'h00 : 6'h21};
        vt[7]  = '{1'b0, 7'd5,  OFS ? 6'h00 : 6'h21};
        vt[8]  = '{1'b1, 7'd6,  OFS ? 6'h02 : 6'h03};
        vt[9]  = '{1'b0, 7'd10, OFS ? 6'h01 : 6'h02};
        vt[10] = '{1'b0, 7'd11, OFS ? 6'h03 : 6'h04};
        vt[11] = '{1'b0, 7'd12, OFS ? 6'h01 : 6'h02};
        vt[12] = '{1'b0, 7'd13, OFS ? 6'h01 : 6'h02};
        vt[13] = '{1'b0, 7'd14, 6'h00};
        vt[14] = '{1'b0, 7'd20, OFS ? 6'h23 : 6'h24};
        vt[15] = '{1'b0, 7'd0,  6'h00};
        rt[0] = '{5'd2, 5'd5, 7'd7,  1'b1, 0,  4, 4};
        rt[1] = '{5'd3, 5'd6, 7'd2,  1'b0, 4,  2, 2};
        rt[2] = '{5'd1, 5'd3, 7'd6,  1'b1, 6,  3, 3};
        rt[3] = '{5'd2, 5'd4, 7'd11, 1'b0, 9,  5, 4};
        rt[4] = '{5'd3, 5'd3, 7'd0,  1'b1, 14, 0, 0};
        rt[5] = '{5'd2, 5'd4, 7'd20, 1'b1, 14, 0, 1};

        repeat (3) tick();
        i_rst = 1'b0;
        tick();
        chk("rst_vld", o_c2v_vld, 0);
        chk("rst_c2v", o_c2v, 0);
        chk("rst_idx", o_c2v_idx, 0);
        chk("rst_done", o_row_done, 0);
        chk("rst_ovf", o_err_ovf, 0);
        chk("rst_in_rdy", o_in_rdy, 1);

        // basic row
        load_row(0);
        drain(0, -1, 0);
        chk("basic_nbeats", nb, 4);
        check_beats("basic", 0, 0);
        chk("basic_latency", first_cyc, 1);
        chk("basic_ndone", ndone, 1);
        chk("basic_done_gap", done_gap, 1);

        // backpressure after 2nd beat
        load_row(0);
        drain(0, 2, 3);
        chk("bp_nbeats", nb, 4);
        check_beats("bp", 0, 0);
        chk("bp_nstall", nstall, 3);
        chk("bp_ndone", ndone, 1);

        // zero magnitude
        load_row(2);
        drain(2, -1, 0);
        chk("zero_nbeats", nb, 3);
        check_beats("zero", 2, 0);

        // ping-pong: A stalled, B closed behind it, C edge waits for A's done
        i_c2v_rdy = 1'b0;
        load_row(0);
        load_row(1);
        chk("pp_rdy_blocked", o_in_rdy, 0);
        i_c2v_rdy = 1'b1;
        i_vld = 1'b1; i_sign = vt[14].sign; i_col_cnt = vt[14].col;
        c_acc = -1; d0 = -1; bfirst = -1; nb = 0; ndone = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (o_c2v_vld) begin
                if (nb < 16) begin
                    bc2v[nb] = o_c2v;
                    bidx[nb] = o_c2v_idx;
                end
                if (nb == rt[0].n_beat && bfirst < 0) bfirst = cyc;
                nb++;
            end
            if (o_row_done) begin
                if (d0 < 0) d0 = cyc;
                ndone++;
            end
            if (i_vld && o_in_rdy && c_acc < 0) c_acc = cyc;
            tick();
            if (c_acc >= 0) i_vld = 1'b0;
        end
        i_vld = 1'b0;
        chk("pp_nbeats", nb, 6);
        chk("pp_ndone", ndone, 2);
        chk("pp_c_accept", c_acc, d0 + 1);
        chk("pp_b_first", bfirst, d0 + 2);
        check_beats("pp_a", 0, 0);
        check_beats("pp_b", 1, 4);
        close_row(5);
        drain(5, -1, 0);
        chk("pp_c_nbeats", nb, 1);
        check_beats("pp_c", 5, 0);

        // overflow, then empty row
        chk("ovf_before", o_err_ovf, 0);
        load_row(3);
        drain(3, -1, 0);
        chk("ovf_nbeats", nb, 4);
        check_beats("ovf", 3, 0);
        chk("ovf_set", o_err_ovf, 1);
        load_row(4);
        drain(4, -1, 0);
        chk("empty_nbeats", nb, 0);
        chk("empty_ndone", ndone, 1);
        chk("ovf_sticky", o_err_ovf, 1);

        // reset mid-emission
        load_row(0);
        cnt2 = 0;
        for (int cyc = 0; cyc < 20 && cnt2 < 2; cyc++) begin
            @(negedge clk);
            if (o_c2v_vld && i_c2v_rdy) cnt2++;
            if (cnt2 < 2) tick();
        end
        chk("mid_two_beats", cnt2, 2);
        tick();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        chk("mid_vld", o_c2v_vld, 0);
        chk("mid_in_rdy", o_in_rdy, 1);
        chk("mid_ovf", o_err_ovf, 0);
        load_row(2);
        drain(2, -1, 0);
        chk("mid_nbeats", nb, 3);
        check_beats("mid", 2, 0);
        chk("mid_ndone", ndone, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
